// File: rtl/encrypt_aes128.sv
// ---------------------------------------------------------------------------
// encrypt_aes128 - iterative AES-128 encryptor, one round per clock, with the
// round keys expanded on the fly alongside the data path.
//
// aes_sbox (also in this file) is the shared combinational S-box. It computes
// the GF(2^8) inverse followed by the FIPS-197 affine transform.
//
// Ports
//   clk       in   1    rising-edge clock
//   encReset  in   1    asynchronous, active-low reset
//   start     in   1    request, sampled only while idle
//   in        in   128  plaintext, in[127:120] is FIPS byte 0
//   key       in   128  cipher key, same byte order
//   out       out  128  ciphertext, same byte order
//   busy      out  1    high while rounds execute (FSM in RUN); this is also
//                       the FSM state as seen from outside
//   done      out  1    one-cycle pulse on the edge that updates out
//
// Handshake: start is accepted on any edge where busy=0 and start=1; in/key
// are captured on that edge only. done rises exactly NUM_ROUNDS edges later,
// for one cycle. busy is already low in that cycle, so a start held high then
// is accepted. A start seen while busy=1 is dropped, not queued.
// ---------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // The inverse is x^254, built as x^2 * x^4 * ... * x^128. This also maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [7:0] b;
  assign b = gf_inv(a);
  assign s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
             {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module encrypt_aes128 #(
  parameter int NUM_ROUNDS         = 10,
  parameter bit CLEAR_OUT_ON_START = 1'b0
) (
  input  logic         clk,
  input  logic         encReset,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
);
  localparam int RW = $clog2(NUM_ROUNDS + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [127:0]  state_q, state_d;
  logic [127:0]  rk_q, rk_d;
  logic [127:0]  out_q, out_d;
  logic [7:0]    rcon_q, rcon_d;
  logic [RW-1:0] round_q, round_d;
  logic          done_q, done_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Bytes are numbered as in FIPS-197: byte i = row (i%4), column (i/4).
  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [127:0] sr_flat, mc_flat;

  for (genvar g = 0; g < 16; g++) begin : g_sub
    aes_sbox u_sbox (.a(state_q[127-8*g -: 8]), .s(sb[g]));
    assign sr_flat[127-8*g -: 8] = sr[g];
    assign mc_flat[127-8*g -: 8] = mc[g];
  end

  // ShiftRows: row r rotates left by r columns.
  for (genvar r = 0; r < 4; r++) begin : g_sr_row
    for (genvar c = 0; c < 4; c++) begin : g_sr_col
      assign sr[r+4*c] = sb[r+4*((c+r)%4)];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mc
    assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
    assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
    assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
  end

  // Key schedule step: SubWord(RotWord(w3)) feeds w0, then each word chains.
  logic [31:0]  w3_rot, sub_w;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] rk_next;

  assign w3_rot = {rk_q[23:0], rk_q[31:24]};
  for (genvar k = 0; k < 4; k++) begin : g_key_sub
    aes_sbox u_sbox (.a(w3_rot[31-8*k -: 8]), .s(sub_w[31-8*k -: 8]));
  end
  assign w0_n    = rk_q[127:96] ^ sub_w ^ {rcon_q, 24'h000000};
  assign w1_n    = rk_q[95:64] ^ w0_n;
  assign w2_n    = rk_q[63:32] ^ w1_n;
  assign w3_n    = rk_q[31:0] ^ w2_n;
  assign rk_next = {w0_n, w1_n, w2_n, w3_n};

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d = in ^ key;
          rk_d    = key;
          rcon_d  = 8'h01;
          round_d = RW'(1);
          fsm_d   = RUN;
          if (CLEAR_OUT_ON_START) out_d = '0;
        end
      end
      RUN: begin
        rk_d   = rk_next;
        rcon_d = xtime(rcon_q);
        if (round_q == RW'(NUM_ROUNDS)) begin
          // Final round skips MixColumns.
          out_d   = sr_flat ^ rk_next;
          done_d  = 1'b1;
          round_d = '0;
          fsm_d   = IDLE;
        end else begin
          state_d = mc_flat ^ rk_next;
          round_d = round_q + RW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge encReset) begin
    if (!encReset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      out_q   <= '0;
      rcon_q  <= 8'h01;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      out_q   <= out_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = (fsm_q == RUN);
  assign done = done_q;
endmodule
